// File: rtl/lut_layer_seq_if.sv
// Handshake, result and configuration bus of the time-multiplexed LUT layer.
// master = upstream/config side, slave = lut_layer_seq.
interface lut_layer_seq_if #(
  parameter int NUM_NEURONS = 16,
  parameter int NUM_IN      = 32,
  parameter int IDX_W       = 5,
  parameter int NID_W       = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [2*NUM_IN-1:0]      in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [2*NUM_NEURONS-1:0] out_data;
  logic                     cfg_we;
  logic                     cfg_sel;
  logic [NID_W+5:0]         cfg_addr;
  logic [IDX_W-1:0]         cfg_data;
  logic                     cfg_drop;
  logic                     busy;

  modport master (
    output in_valid, in_data, out_ready, cfg_we, cfg_sel, cfg_addr, cfg_data,
    input  in_ready, out_valid, out_data, cfg_drop, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready, cfg_we, cfg_sel, cfg_addr, cfg_data,
    output in_ready, out_valid, out_data, cfg_drop, busy
  );
endinterface

// File: rtl/lut_layer_seq.sv
// Sequential evaluator for one LogicNet layer: one 64x2-bit lookup shared by
// all neurons, two clocks per neuron (FETCH forms the address, LOOK reads it).
module lut_layer_seq #(
  parameter int NUM_NEURONS = 16,
  parameter int NUM_IN      = 32,
  parameter int IDX_W       = 5,
  parameter int NID_W       = 4
) (
  input  logic         clk,
  input  logic         rst,
  lut_layer_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FETCH, LOOK, OUT} state_t;

  state_t                   state_reg, state_next;
  logic [2*NUM_IN-1:0]      in_reg;
  logic [NID_W-1:0]         n_reg;
  logic [5:0]               addr_reg;
  logic [2*NUM_NEURONS-1:0] out_data_reg;
  logic                     cfg_drop_reg;

  // Configuration storage; deliberately not reset so it survives rst.
  logic [1:0]       lut_mem  [NUM_NEURONS][64];
  logic [IDX_W-1:0] conn_mem [NUM_NEURONS][3];

  // Config decode. Out-of-range neuron numbers (only possible when
  // NUM_NEURONS is not a power of two) are treated like malformed writes.
  logic [NID_W-1:0] cfg_neuron;
  logic [5:0]       cfg_entry;
  logic [1:0]       cfg_slot;
  logic             cfg_fmt_ok;
  logic             cfg_accept;

  assign cfg_neuron = bus.cfg_addr[NID_W+5:6];
  assign cfg_entry  = bus.cfg_addr[5:0];
  assign cfg_slot   = bus.cfg_addr[1:0];
  assign cfg_fmt_ok = ({1'b0, cfg_neuron} < (NID_W+1)'(NUM_NEURONS)) &&
                      (!bus.cfg_sel || (bus.cfg_addr[5:2] == 4'd0 && cfg_slot != 2'd3));
  assign cfg_accept = bus.cfg_we && (state_reg == IDLE) && cfg_fmt_ok;

  // Feature selection for the current neuron: slot 0 lands in addr[1:0].
  logic [1:0] feat [3];
  logic       last_neuron;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_feat
      assign feat[gi] = in_reg[{conn_mem[n_reg][gi], 1'b0} +: 2];
    end
  endgenerate

  assign last_neuron = (n_reg == NID_W'(NUM_NEURONS - 1));

  // Config storage writes (only in IDLE, including the accept cycle).
  always_ff @(posedge clk) begin
    if (cfg_accept) begin
      if (bus.cfg_sel) begin
        conn_mem[cfg_neuron][cfg_slot] <= bus.cfg_data;
      end else begin
        lut_mem[cfg_neuron][cfg_entry] <= bus.cfg_data[1:0];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (bus.in_valid) state_next = FETCH;
      FETCH: state_next = LOOK;
      LOOK:  state_next = last_neuron ? OUT : FETCH;
      OUT:   if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: input latch, neuron counter, lookup address, result vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_reg       <= '0;
      n_reg        <= '0;
      addr_reg     <= '0;
      out_data_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            in_reg <= bus.in_data;
            n_reg  <= '0;
          end
        end
        FETCH: addr_reg <= {feat[2], feat[1], feat[0]};
        LOOK: begin
          out_data_reg[{n_reg, 1'b0} +: 2] <= lut_mem[n_reg][addr_reg];
          if (!last_neuron) n_reg <= n_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Rejected config writes report one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_drop_reg <= 1'b0;
    end else begin
      cfg_drop_reg <= bus.cfg_we && !cfg_accept;
    end
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == OUT);
  assign bus.busy      = (state_reg == FETCH) || (state_reg == LOOK);
  assign bus.out_data  = out_data_reg;
  assign bus.cfg_drop  = cfg_drop_reg;

endmodule
